// File: rtl/id_decode_stage_pkg.sv
// ISA constants and field helpers for the MIPS decode stage.
package id_decode_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;

    // R-type function codes that redirect fetch
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;

    // Canonical nop (sll r0, r0, 0)
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // How the 16-bit immediate is widened
    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_LUI  = 2'd2
    } ext_kind_e;

    function automatic logic [5:0]  f_op(input logic [31:0] ir);    return ir[31:26]; endfunction
    function automatic logic [4:0]  f_rs(input logic [31:0] ir);    return ir[25:21]; endfunction
    function automatic logic [4:0]  f_rt(input logic [31:0] ir);    return ir[20:16]; endfunction
    function automatic logic [5:0]  f_funct(input logic [31:0] ir); return ir[5:0];   endfunction
    function automatic logic [15:0] f_imm(input logic [31:0] ir);   return ir[15:0];  endfunction
    function automatic logic [25:0] f_idx(input logic [31:0] ir);   return ir[25:0];  endfunction

    function automatic ext_kind_e ext_kind(input logic [5:0] op);
        ext_kind_e k;
        k = EXT_SIGN;
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) k = EXT_ZERO;
        else if (op == OP_LUI)                             k = EXT_LUI;
        return k;
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// Bundle of decode-stage signals between the pipeline control/datapath (master)
// and the decode stage (slave).
//
// Flow control: there is no ready back-pressure on this stage. stall_d or
// flush_e high at a rising edge makes the D/E register load a bubble
// (all fields zero, valid_e=0); otherwise the D/E register captures the
// current instruction and valid_e=1 marks it as real work for E.
interface id_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            stall_d;
    logic            flush_e;
    logic [31:0]     ir_d;
    logic [XLEN-1:0] pc4_d;
    logic [XLEN-1:0] fwd_rs_d;
    logic [XLEN-1:0] fwd_rt_d;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic [XLEN-1:0] rf_rs_d;
    logic [XLEN-1:0] rf_rt_d;
    logic            pc_src_d;
    logic [XLEN-1:0] npc_d;
    logic [31:0]     ir_e;
    logic [XLEN-1:0] pc4_e;
    logic [XLEN-1:0] rs_e;
    logic [XLEN-1:0] rt_e;
    logic [XLEN-1:0] ext_e;
    logic            valid_e;

    modport master (
        output stall_d, flush_e, ir_d, pc4_d, fwd_rs_d, fwd_rt_d,
               wb_we, wb_addr, wb_data,
        input  rf_rs_d, rf_rt_d, pc_src_d, npc_d,
               ir_e, pc4_e, rs_e, rt_e, ext_e, valid_e
    );

    modport slave (
        input  stall_d, flush_e, ir_d, pc4_d, fwd_rs_d, fwd_rt_d,
               wb_we, wb_addr, wb_data,
        output rf_rs_d, rf_rt_d, pc_src_d, npc_d,
               ir_e, pc4_e, rs_e, rt_e, ext_e, valid_e
    );
endinterface

// File: rtl/id_decode_stage_regfile.sv
// 2-read / 1-write register file with write-through bypass; r0 reads zero.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    // Next register contents: a single write per cycle, r0 never written
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0) && (int'(waddr) < NREG)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port A; a same-cycle write is returned directly so W->D needs no stall.
    // Bypass is suppressed in reset so reads show the cleared file immediately.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            if (we && !rst && (raddr_a == waddr)) rdata_a = wdata;
            else if (int'(raddr_a) < NREG)       rdata_a = mem_q[raddr_a];
        end
    end

    // Read port B, same rules as port A
    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            if (we && !rst && (raddr_b == waddr)) rdata_b = wdata;
            else if (int'(raddr_b) < NREG)       rdata_b = mem_q[raddr_b];
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// MIPS decode stage: register read, immediate extension, branch/jump
// resolution in D and the D/E pipeline register.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic               clk,
    input  logic               reset,
    id_decode_stage_if.slave   bus
);

    logic [5:0]      op;
    logic [4:0]      rs_f;
    logic [4:0]      rt_f;
    logic [5:0]      funct;
    logic [15:0]     imm;
    logic [25:0]     idx;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] ext_c;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic [XLEN-1:0] npc_c;
    logic            redirect_c;
    logic            rs_neg;
    logic            rs_zero;

    assign op       = f_op(bus.ir_d);
    assign rs_f     = f_rs(bus.ir_d);
    assign rt_f     = f_rt(bus.ir_d);
    assign funct    = f_funct(bus.ir_d);
    assign imm      = f_imm(bus.ir_d);
    assign idx      = f_idx(bus.ir_d);
    assign imm_sext = {{(XLEN-16){imm[15]}}, imm};

    id_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
        .clk     (clk),
        .rst     (reset),
        .we      (bus.wb_we),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (AW'(rs_f)),
        .raddr_b (AW'(rt_f)),
        .rdata_a (bus.rf_rs_d),
        .rdata_b (bus.rf_rt_d)
    );

    // Immediate widening chosen by opcode
    always_comb begin
        ext_c = imm_sext;
        case (ext_kind(op))
            EXT_ZERO: ext_c = XLEN'(imm);
            EXT_LUI:  ext_c = XLEN'({imm, 16'h0000});
            default:  ext_c = imm_sext;
        endcase
    end

    assign br_target = bus.pc4_d + (imm_sext << 2);
    assign j_target  = {bus.pc4_d[XLEN-1:28], idx, 2'b00};
    assign rs_neg    = bus.fwd_rs_d[XLEN-1];
    assign rs_zero   = (bus.fwd_rs_d == '0);

    // Early branch/jump resolution on the forwarded operands (signed compares)
    always_comb begin
        npc_c      = bus.pc4_d;
        redirect_c = 1'b0;
        case (op)
            OP_BEQ: begin
                npc_c      = br_target;
                redirect_c = (bus.fwd_rs_d == bus.fwd_rt_d);
            end
            OP_BNE: begin
                npc_c      = br_target;
                redirect_c = (bus.fwd_rs_d != bus.fwd_rt_d);
            end
            OP_BLEZ: begin
                npc_c      = br_target;
                redirect_c = rs_neg || rs_zero;
            end
            OP_BGTZ: begin
                npc_c      = br_target;
                redirect_c = !rs_neg && !rs_zero;
            end
            OP_REGIMM: begin
                if (rt_f == RT_BLTZ) begin
                    npc_c      = br_target;
                    redirect_c = rs_neg;
                end else if (rt_f == RT_BGEZ) begin
                    npc_c      = br_target;
                    redirect_c = !rs_neg;
                end
            end
            OP_J, OP_JAL: begin
                npc_c      = j_target;
                redirect_c = 1'b1;
            end
            OP_RTYPE: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    npc_c      = bus.fwd_rs_d;
                    redirect_c = 1'b1;
                end
            end
            default: begin
                npc_c      = bus.pc4_d;
                redirect_c = 1'b0;
            end
        endcase
    end

    // Operands are not final while stalled, so never redirect then
    assign bus.npc_d    = npc_c;
    assign bus.pc_src_d = redirect_c && !bus.stall_d;

    logic [31:0]     ir_e_q,  ir_e_d;
    logic [XLEN-1:0] pc4_e_q, pc4_e_d;
    logic [XLEN-1:0] rs_e_q,  rs_e_d;
    logic [XLEN-1:0] rt_e_q,  rt_e_d;
    logic [XLEN-1:0] ext_e_q, ext_e_d;
    logic            valid_e_q, valid_e_d;

    // D/E next value: bubble on stall or flush, otherwise capture D
    always_comb begin
        ir_e_d    = NOP_INSN;
        pc4_e_d   = '0;
        rs_e_d    = '0;
        rt_e_d    = '0;
        ext_e_d   = '0;
        valid_e_d = 1'b0;
        if (!(bus.stall_d || bus.flush_e)) begin
            ir_e_d    = bus.ir_d;
            pc4_e_d   = bus.pc4_d;
            rs_e_d    = bus.fwd_rs_d;
            rt_e_d    = bus.fwd_rt_d;
            ext_e_d   = ext_c;
            valid_e_d = 1'b1;
        end
    end

    // D/E register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_e_q    <= '0;
            pc4_e_q   <= '0;
            rs_e_q    <= '0;
            rt_e_q    <= '0;
            ext_e_q   <= '0;
            valid_e_q <= 1'b0;
        end else begin
            ir_e_q    <= ir_e_d;
            pc4_e_q   <= pc4_e_d;
            rs_e_q    <= rs_e_d;
            rt_e_q    <= rt_e_d;
            ext_e_q   <= ext_e_d;
            valid_e_q <= valid_e_d;
        end
    end

    assign bus.ir_e    = ir_e_q;
    assign bus.pc4_e   = pc4_e_q;
    assign bus.rs_e    = rs_e_q;
    assign bus.rt_e    = rt_e_q;
    assign bus.ext_e   = ext_e_q;
    assign bus.valid_e = valid_e_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed literal cases followed by random
// instruction streams, checked every cycle against a behavioural model.
module tb_id_decode_stage;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   started;

    id_decode_stage_if #(.XLEN(32), .AW(5)) bus ();

    id_decode_stage #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [32];
    logic [31:0] m_ir_e, m_pc4_e, m_rs_e, m_rt_e, m_ext_e;
    logic        m_valid_e;

    function automatic int sext16(input logic [15:0] v);
        int s;
        s = int'(v);
        if (s >= 32768) s = s - 65536;
        return s;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] ir);
        int op;
        op = int'(ir[31:26]);
        if (op == 12 || op == 13 || op == 14) return {16'h0, ir[15:0]};
        if (op == 15) return 32'(int'(ir[15:0]) * 65536);
        return 32'(sext16(ir[15:0]));
    endfunction

    function automatic bit m_redirect(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt);
        int op, a, b, rtf, fn;
        op = int'(ir[31:26]); rtf = int'(ir[20:16]); fn = int'(ir[5:0]);
        a = $signed(rs); b = $signed(rt);
        case (op)
            4: return a == b;
            5: return a != b;
            6: return a <= 0;
            7: return a > 0;
            1: return (rtf == 0) ? (a < 0) : (rtf == 1) ? (a >= 0) : 1'b0;
            2, 3: return 1'b1;
            0: return (fn == 8 || fn == 9);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] rs);
        int op, rtf, fn;
        logic [31:0] tgt;
        op = int'(ir[31:26]); rtf = int'(ir[20:16]); fn = int'(ir[5:0]);
        tgt = pc4 + 32'(sext16(ir[15:0]) * 4);
        if (op >= 4 && op <= 7) return tgt;
        if (op == 1 && rtf <= 1) return tgt;
        if (op == 2 || op == 3) return (pc4 & 32'hF000_0000) | (32'(ir[25:0]) * 4);
        if (op == 0 && (fn == 8 || fn == 9)) return rs;
        return pc4;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'h0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    // Model state: RF write plus D/E transfer at each rising edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
            m_ir_e <= 0; m_pc4_e <= 0; m_rs_e <= 0; m_rt_e <= 0; m_ext_e <= 0; m_valid_e <= 0;
        end else begin
            if (bus.wb_we && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] <= bus.wb_data;
            if (bus.stall_d || bus.flush_e) begin
                m_ir_e <= 0; m_pc4_e <= 0; m_rs_e <= 0; m_rt_e <= 0; m_ext_e <= 0; m_valid_e <= 0;
            end else begin
                m_ir_e <= bus.ir_d; m_pc4_e <= bus.pc4_d; m_rs_e <= bus.fwd_rs_d;
                m_rt_e <= bus.fwd_rt_d; m_ext_e <= m_ext(bus.ir_d); m_valid_e <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: all outputs against the model on every falling edge
    always @(negedge clk) begin
        if (started) begin
            check("rf_rs_d", bus.rf_rs_d, m_read(bus.ir_d[25:21]));
            check("rf_rt_d", bus.rf_rt_d, m_read(bus.ir_d[20:16]));
            check("pc_src_d", 32'(bus.pc_src_d),
                  32'(m_redirect(bus.ir_d, bus.fwd_rs_d, bus.fwd_rt_d) && !bus.stall_d));
            check("npc_d", bus.npc_d, m_npc(bus.ir_d, bus.pc4_d, bus.fwd_rs_d));
            check("ir_e", bus.ir_e, m_ir_e);
            check("pc4_e", bus.pc4_e, m_pc4_e);
            check("rs_e", bus.rs_e, m_rs_e);
            check("rt_e", bus.rt_e, m_rt_e);
            check("ext_e", bus.ext_e, m_ext_e);
            check("valid_e", 32'(bus.valid_e), 32'(m_valid_e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.stall_d = 0; bus.flush_e = 0; bus.ir_d = 32'h0; bus.pc4_d = 32'h0;
        bus.fwd_rs_d = 0; bus.fwd_rt_d = 0; bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    endtask

    task automatic drive_random();
        logic [5:0] ops [15];
        logic [5:0] fns [4];
        logic [5:0] op;
        logic [31:0] ir;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h08, 6'h09, 6'h21, 6'h20};
        op = ops[$urandom_range(0, 14)];
        ir = $urandom;
        ir[31:26] = op;
        if (op == 6'h00) ir[5:0] = fns[$urandom_range(0, 3)];
        if (op == 6'h01) ir[20:16] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) ir = 32'h0;
        bus.ir_d = ir;
        bus.pc4_d = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        case ($urandom_range(0, 3))
            0: bus.fwd_rs_d = 32'h0;
            1: bus.fwd_rs_d = 32'h8000_0000 | $urandom;
            default: bus.fwd_rs_d = $urandom;
        endcase
        bus.fwd_rt_d = ($urandom_range(0, 2) == 0) ? bus.fwd_rs_d : $urandom;
        bus.wb_we   = 1'($urandom_range(0, 1));
        bus.wb_addr = ($urandom_range(0, 2) == 0) ? ir[25:21] : 5'($urandom_range(0, 31));
        bus.wb_data = $urandom;
        bus.stall_d = ($urandom_range(0, 7) == 0);
        bus.flush_e = ($urandom_range(0, 7) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vectors = 0; miscompares = 0; started = 0;
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        started = 1;
        next_cycle();
        reset = 1'b0;
        check("reset_valid_e", 32'(bus.valid_e), 32'h0);
        check("reset_ir_e", bus.ir_e, 32'h0);

        // write r5, then read it back through rs
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_1234;
        next_cycle();
        bus.wb_we = 0; bus.ir_d = 32'h24A5_0000;
        #1 check("r5_read", bus.rf_rs_d, 32'h0000_1234);
        check("valid_after_nop", 32'(bus.valid_e), 32'h1);
        next_cycle();
        reset = 1'b1;
        #1 check("reset_mid_rf", bus.rf_rs_d, 32'h0);
        check("reset_mid_valid", 32'(bus.valid_e), 32'h0);
        check("reset_mid_ir_e", bus.ir_e, 32'h0);
        next_cycle();
        reset = 1'b0;
        #1 check("rf_lost", bus.rf_rs_d, 32'h0);

        // write-through bypass
        bus.wb_we = 1; bus.wb_addr = 5'd8; bus.wb_data = 32'hDEAD_BEEF; bus.ir_d = 32'h2500_0000;
        #1 check("bypass_r8", bus.rf_rs_d, 32'hDEAD_BEEF);
        next_cycle();
        bus.wb_addr = 5'd0; bus.ir_d = 32'h2000_0000;
        #1 check("bypass_r0", bus.rf_rs_d, 32'h0);
        next_cycle();
        bus.wb_we = 0;

        // bltz / bgtz with a negative operand
        bus.pc4_d = 32'h0000_3004; bus.fwd_rs_d = 32'h8000_0000; bus.ir_d = 32'h0420_FFFF;
        #1 check("bltz_taken", 32'(bus.pc_src_d), 32'h1);
        check("bltz_npc", bus.npc_d, 32'h0000_3000);
        next_cycle();
        bus.ir_d = 32'h1C20_FFFF;
        #1 check("bgtz_not_taken", 32'(bus.pc_src_d), 32'h0);
        next_cycle();

        // j, then the same j under stall
        bus.pc4_d = 32'h0000_3008; bus.ir_d = 32'h0800_0C05;
        #1 check("j_npc", bus.npc_d, 32'h0000_3014);
        check("j_taken", 32'(bus.pc_src_d), 32'h1);
        next_cycle();
        bus.stall_d = 1;
        #1 check("j_stalled", 32'(bus.pc_src_d), 32'h0);
        next_cycle();
        bus.stall_d = 0;

        // immediate extension forms
        bus.ir_d = 32'h3C01_8001;
        next_cycle();
        check("lui_ext", bus.ext_e, 32'h8001_0000);
        bus.ir_d = 32'h3401_8001;
        next_cycle();
        check("ori_ext", bus.ext_e, 32'h0000_8001);
        bus.ir_d = 32'h2401_8001;
        next_cycle();
        check("addiu_ext", bus.ext_e, 32'hFFFF_8001);

        // stall then flush: two bubbles, then capture
        bus.ir_d = 32'h2401_0007; bus.stall_d = 1;
        next_cycle();
        check("stall_bubble_ir", bus.ir_e, 32'h0);
        check("stall_bubble_v", 32'(bus.valid_e), 32'h0);
        bus.stall_d = 0; bus.flush_e = 1;
        next_cycle();
        check("flush_bubble_ir", bus.ir_e, 32'h0);
        check("flush_bubble_v", 32'(bus.valid_e), 32'h0);
        bus.flush_e = 0;
        next_cycle();
        check("capture_ir", bus.ir_e, 32'h2401_0007);
        check("capture_v", 32'(bus.valid_e), 32'h1);

        // random streams, with an occasional mid-cycle reset
        for (int n = 0; n < 600; n++) begin
            drive_random();
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                next_cycle();
                reset = 1'b0;
            end else begin
                next_cycle();
            end
        end

        drive_idle();
        next_cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
